display_scan_controller: RTL and testbench
==========================================

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameters SHALL be:
- DWELL_CYCLES, default 100000: clocks each digit is driven (>=1).
- BLANK_CYCLES, default 1000: all-off clocks between digits, for anti-ghosting (>=1).
REQ-002 Ports SHALL be (clock and reset first):
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- value  in  16  four BCD/hex nibbles; digit k = value[4k+3:4k].
- load  in  1  one-cycle strobe capturing value as the pending frame.
- digit_enable  in  4  per-digit enable; 0 blanks that digit.
- display_out  out  4  nibble for the shared seven-segment decoder.
- an  out  4  active-low digit anodes.
- frame_done  out  1  one-cycle pulse at the end of digit 3's dwell.
- load_ack  out  1  one-cycle pulse when a pending value becomes displayed.
REQ-003 There SHALL be one clock; reset SHALL be synchronous and active-low.

Function
REQ-004 All outputs SHALL be registered.
REQ-005 The FSM SHALL have two states, BLANK and DRIVE.
- It SHALL keep a 2-bit digit index sel and a cycle counter cnt sized for max(DWELL_CYCLES, BLANK_CYCLES)-1.
REQ-006 In BLANK:
- an SHALL be 4'b1111.
- cnt SHALL count 0..BLANK_CYCLES-1.
- When cnt = BLANK_CYCLES-1, the FSM SHALL go to DRIVE with cnt <= 0.
REQ-007 On the cycle the FSM enters DRIVE:
- display_out SHALL load shadow[4*sel+3:4*sel].
- an SHALL load ~(4'b0001 << sel) if digit_enable[sel]=1, else 4'b1111.
- digit_enable SHALL be sampled only at DRIVE entry.
REQ-008 In DRIVE:
- an and display_out SHALL hold.
- cnt SHALL count 0..DWELL_CYCLES-1.
- When cnt = DWELL_CYCLES-1, the FSM SHALL go to BLANK with cnt <= 0 and sel <= sel+1 mod 4 (3 wraps to 0).
- display_out SHALL hold its last value during BLANK.
REQ-009 The frame boundary SHALL be the DRIVE->BLANK transition with sel=3.
- frame_done SHALL be 1 for exactly that following cycle and 0 otherwise.
REQ-010 load=1 outside a boundary cycle SHALL set pending_val <= value and pending <= 1.
- A later load before the boundary SHALL overwrite pending_val (last wins).
REQ-011 At a frame boundary with pending=1 or load=1:
- shadow SHALL load (load ? value : pending_val).
- pending SHALL clear.
- load_ack SHALL pulse 1 cycle, coincident with frame_done.
REQ-012 Shadow SHALL change only at frame boundaries, so no frame ever mixes old and new digits.
REQ-013 A boundary with no pending value and no load SHALL leave shadow unchanged, with no load_ack.
REQ-014 A full scan period SHALL be 4*(BLANK_CYCLES+DWELL_CYCLES) clocks.
- Each digit SHALL be anode-active for exactly DWELL_CYCLES consecutive clocks per frame when enabled.
REQ-015 At most one anode bit SHALL be 0 at any time.

Reset
REQ-016 reset_n=0 at a clock edge SHALL set, on the next cycle:
- state=BLANK, sel=0, cnt=0.
- an=4'b1111, display_out=4'h0.
- shadow=16'h0000, pending_val=16'h0000, pending=0.
- frame_done=0, load_ack=0.
REQ-017 Reset mid-DRIVE SHALL force an=4'b1111 the next cycle and discard any pending load.
REQ-018 After release, the first DRIVE SHALL begin BLANK_CYCLES clocks later, on digit 0.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2)
REQ-019 Scan order: reset, value=16'h1234, load at cycle 1, digit_enable=4'hF.
- First frame SHALL show 0 on all digits (anodes 1110,1101,1011,0111, 4 clocks each, 2-clock 1111 gaps).
- Then frame_done and load_ack SHALL pulse together.
- Next frame SHALL be display_out 4,3,2,1 on anodes 1110,1101,1011,0111.
REQ-020 Last-wins: load 16'hAAAA, then load 16'hBBBB, both before the boundary -> one load_ack, displayed nibbles all B.
REQ-021 Boundary collision: load 16'h5678 on the exact boundary cycle -> shadow=16'h5678 that boundary, load_ack pulses, pending=0 afterward.
REQ-022 Blanking: digit_enable=4'b1010 -> an shows only 1101 and 0111 active phases, 1111 elsewhere; the period is still 24 clocks.
REQ-023 Reset mid-operation: assert reset_n=0 in sel=2 DRIVE with a pending load -> an=1111 next cycle, no load_ack ever, first digit 0 drive 2 clocks after release, showing 0.

Source files
------------

// File: rtl/display_scan_controller.sv
// ============================================================================
// Module      : display_scan_controller
// Description : Time-multiplexed 4-digit display scanner. The digit shadow
//               register is updated only at frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan_controller #(
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  digit_enable,
    output logic [3:0]  display_out,
    output logic [3:0]  an,
    output logic        frame_done,
    output logic        load_ack
);

    localparam int c_CNT_MAX = ((DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES) - 1;
    localparam int c_CNT_W   = (c_CNT_MAX < 1) ? 1 : $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [1:0]           r_sel;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [15:0]          r_shadow;
    logic [15:0]          r_pending_val;
    logic                 r_pending;
    logic                 w_blank_end;
    logic                 w_drive_end;
    logic                 w_boundary;

    always_comb begin
        w_blank_end  = (r_state == S_BLANK) && (r_cnt == c_BLANK_LAST);
        w_drive_end  = (r_state == S_DRIVE) && (r_cnt == c_DWELL_LAST);
        w_boundary   = w_drive_end && (r_sel == 2'd3);
        w_next_state = r_state;
        if (w_blank_end) begin
            w_next_state = S_DRIVE;
        end else if (w_drive_end) begin
            w_next_state = S_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_BLANK;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sel         <= 2'd0;
            r_cnt         <= '0;
            an            <= 4'b1111;
            display_out   <= 4'h0;
            r_shadow      <= 16'h0000;
            r_pending_val <= 16'h0000;
            r_pending     <= 1'b0;
            frame_done    <= 1'b0;
            load_ack      <= 1'b0;
        end else begin
            frame_done <= w_boundary;
            load_ack   <= 1'b0;

            if (w_blank_end || w_drive_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Digit nibble and anode are latched once at DRIVE entry and held
            if (w_blank_end) begin
                display_out <= r_shadow[{r_sel, 2'b00} +: 4];
                an          <= digit_enable[r_sel] ? ~(4'b0001 << r_sel) : 4'b1111;
            end

            if (w_drive_end) begin
                an    <= 4'b1111;
                r_sel <= r_sel + 2'd1;
            end

            // A load coinciding with the boundary bypasses the pending register
            if (w_boundary) begin
                if (r_pending || load) begin
                    r_shadow <= load ? value : r_pending_val;
                    load_ack <= 1'b1;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending_val <= value;
                r_pending     <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_display_scan_controller.sv
// ============================================================================
// Module      : tb_display_scan_controller
// Description : Directed self-checking bench for display_scan_controller
//               with DWELL_CYCLES=4, BLANK_CYCLES=2 (24-clock frame).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_scan_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] value;
    logic        load;
    logic [3:0]  digit_enable;
    logic [3:0]  display_out;
    logic [3:0]  an;
    logic        frame_done;
    logic        load_ack;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          k        = 0;
    bit          in_reset;
    bit          ack_flag;
    logic [15:0] exp_shadow;
    logic [15:0] exp_next;
    logic [3:0]  exp_an;
    logic [3:0]  exp_disp;
    logic        exp_fd;
    logic        exp_ack;

    display_scan_controller #(
        .DWELL_CYCLES(4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .value        (value),
        .load         (load),
        .digit_enable (digit_enable),
        .display_out  (display_out),
        .an           (an),
        .frame_done   (frame_done),
        .load_ack     (load_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s k=%0d observed %h expected %h", tag, k, got, exp);
        end
    endtask

    // Expected timing after release: digit d drives for k in [2+6d, 5+6d] of each
    // 24-clock frame; frame_done/load_ack appear at k = 24, 48, ...
    task automatic tick();
        int m;
        int d;
        @(negedge clk);
        load = 1'b0;
        k++;
        if (in_reset) begin
            exp_an   = 4'hF;
            exp_disp = 4'h0;
            exp_fd   = 1'b0;
            exp_ack  = 1'b0;
        end else begin
            exp_fd  = (k >= 24) && (k % 24 == 0);
            exp_ack = exp_fd && ack_flag;
            m = k - 2;
            if (k >= 2 && (m % 6) < 4) begin
                d = (m / 6) % 4;
                if (m % 6 == 0) begin
                    exp_disp = exp_shadow[4*d +: 4];
                    exp_an   = digit_enable[d] ? ~(4'b0001 << d) : 4'hF;
                end
            end else begin
                exp_an = 4'hF;
            end
        end
        chk("an", an, exp_an);
        chk("display_out", display_out, exp_disp);
        chk("frame_done", {3'b000, frame_done}, {3'b000, exp_fd});
        chk("load_ack", {3'b000, load_ack}, {3'b000, exp_ack});
        if (exp_fd) begin
            if (ack_flag) exp_shadow = exp_next;
            ack_flag = 1'b0;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        value    = v;
        load     = 1'b1;
        exp_next = v;
        ack_flag = 1'b1;
    endtask

    task automatic release_reset();
        reset_n    = 1'b1;
        in_reset   = 1'b0;
        k          = 0;
        ack_flag   = 1'b0;
        exp_shadow = 16'h0000;
        exp_next   = 16'h0000;
        exp_an     = 4'hF;
        exp_disp   = 4'h0;
    endtask

    initial begin
        reset_n      = 1'b0;
        value        = 16'h0000;
        load         = 1'b0;
        digit_enable = 4'hF;
        in_reset     = 1'b1;
        repeat (3) tick();
        release_reset();

        // Frame 0 shows zeros; 1234 loaded early appears from frame 1
        tick();
        do_load(16'h1234);
        while (k < 30) tick();

        // Last load before the boundary wins
        do_load(16'hAAAA);
        while (k < 35) tick();
        do_load(16'hBBBB);
        while (k < 71) tick();

        // Load on the exact boundary cycle
        do_load(16'h5678);
        tick();
        value        = 16'hFFFF;
        digit_enable = 4'b1010;
        while (k < 96) tick();

        // Full enable again; pending load then reset in digit 2 DRIVE
        digit_enable = 4'hF;
        while (k < 100) tick();
        do_load(16'h9999);
        while (k < 111) tick();
        reset_n  = 1'b0;
        in_reset = 1'b1;
        tick();
        release_reset();
        while (k < 56) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
